bank_cmd_arbiter: RTL and testbench
===================================

Name: bank_cmd_arbiter

Overview:
- Consumer end of the bank-machine command interface.
- Accepts `cmd_*` streams from NBANKS bank machines, arbitrates them round-robin, and enforces inter-bank timing (tRRD, tCCD, tWTR).
- Runs the refresh handshake towards the banks.
- Presents one registered command stream to the PHY-side command slot.

Parameters:
- NBANKS, 8, number of bank machines; bank index width BW = clog2(NBANKS).
- AW, 17, command address width (matches the bank-machine `cmd_payload_a`).

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  asynchronous active-low reset
- bank_cmd_valid  in  NBANKS  per-bank cmd_valid
- bank_cmd_ready  out  NBANKS  per-bank cmd_ready
- bank_cmd_first  out  NBANKS  per-bank cmd_first
- bank_cmd_last  out  NBANKS  per-bank cmd_last
- bank_cmd_a  in  NBANKS*AW  per-bank address; bank i occupies bits [i*AW +: AW]
- bank_cmd_ba  in  NBANKS*3  per-bank bank address
- bank_cmd_cas / bank_cmd_ras / bank_cmd_we  in  NBANKS each  per-bank command bits
- bank_cmd_is_cmd / bank_cmd_is_read / bank_cmd_is_write  in  NBANKS each  per-bank type flags
- bank_refresh_req  out  NBANKS  refresh request to each bank machine
- bank_refresh_gnt  in  NBANKS  refresh grant from each bank machine
- ref_req  in  1  request from the refresher
- ref_ack  out  1  one-cycle pulse when the REFRESH command is accepted by the PHY side
- out_valid  out  1  output command valid
- out_ready  in  1  output command ready
- out_a  out  AW  output address
- out_ba  out  3  output bank address
- out_cas / out_ras / out_we  out  1 each  output command bits
- out_is_read / out_is_write  out  1 each  output type flags
- tRRD_cfg / tCCD_cfg / tWTR_cfg  in  8 each  cycle counts; 0 and 1 both mean no extra spacing

Behaviour:
- Reset (async, `sys_rst_n` = 0):
  - All output registers clear to 0, including `out_valid`.
  - Round-robin pointer = 0; FSM = NORMAL.
  - All timing counters ready = 1, count = 0.
  - Release is synchronous to `sys_clk`.
- Reset mid-transfer: the in-flight output command is dropped, and no `ref_ack` is produced for it.
- Command classes, decoded from bank inputs:
  - ACT = ras & ~cas & ~we
  - CASRD = cas & is_read
  - CASWR = cas & is_write
  - any other valid command = OTHER (precharge), which has no spacing constraint.
- Eligibility of bank i: `bank_cmd_valid[i]` AND the timing for its class:
  - ACT requires `trrd_ready`.
  - CASRD requires `tccd_ready` & `twtr_ready`.
  - CASWR requires `tccd_ready`.
- Load condition: `load = (~out_valid | out_ready)` & FSM == NORMAL & any bank eligible.
- Grant:
  - The eligible bank with the lowest index at or after the pointer, wrapping modulo NBANKS.
  - `bank_cmd_ready[g] = load`; all other ready bits are 0.
  - `bank_cmd_first` and `bank_cmd_last` equal `bank_cmd_ready` (single-beat commands).
  - Ready is combinational, so a bank's cmd_valid & cmd_ready handshake completes in the same cycle.
- Latency and output rules:
  - On load, the granted payload is registered onto `out_*` and `out_valid` = 1 on the next cycle.
  - Pointer becomes g+1, wrapping NBANKS-1 to 0.
  - `out_valid` is held, with payload stable, until `out_ready`.
  - Back-to-back loads every cycle are allowed while `out_ready` = 1.
  - With no load and `out_ready` = 1, `out_valid` clears.
- Timing counters (same scheme for all three):
  - Each counter has a load event; on load: count = cfg-1, ready = (cfg-1 == 0).
  - Otherwise, while not ready: count decrements, and ready becomes 1 when count == 1.
  - tRRD loads on ACT; tCCD loads on CASRD or CASWR; tWTR loads on CASWR.
  - The load event occurs on the grant cycle.
  - Result: the next same-class command can be granted cfg cycles after the previous grant.
  - cfg = 0 behaves as cfg = 1 (back-to-back).
- Refresh FSM:
  - NORMAL:
    - `ref_req` = 1 moves to DRAIN.
    - `ref_req` has priority over a same-cycle grant: no load occurs that cycle.
  - DRAIN:
    - `bank_refresh_req` = all ones; no grants.
    - Moves to ISSUE when `&bank_refresh_gnt` and (`~out_valid` | `out_ready`).
  - ISSUE:
    - Loads a REFRESH command onto the output: cas = 1, ras = 1, we = 0, a = 0, ba = 0, is_read = is_write = 0.
    - Moves to WAIT.
  - WAIT:
    - On `out_valid` & `out_ready`: `ref_ack` = 1 for that cycle; moves to DONE.
  - DONE:
    - `bank_refresh_req` held at all ones until `ref_req` = 0, then NORMAL.
    - `bank_refresh_req` drops on entry to NORMAL.
- Refresh with timing counters: timing counters keep running during refresh. The REFRESH command does not load any counter.
- Simultaneous events:
  - A grant and `out_ready` in the same cycle replace the output register; there is no bubble.
  - If `ref_req` drops during DRAIN, the FSM still completes the refresh.

Test Plan:
- Banks 0, 3 and 5 hold a CASRD each; tCCD = 1; `out_ready` = 1 -> outputs in order 0, 3, 5 on consecutive cycles, each one cycle after its grant; pointer = 6 afterwards.
- Banks 1 and 2 each hold an ACT; tRRD = 4 -> bank 1 granted at cycle t, bank 2 at t+4; `bank_cmd_ready[2]` = 0 during t+1..t+3.
- CASWR from bank 0 then a CASRD pending on bank 1; tWTR = 6, tCCD = 2 -> the read is granted exactly 6 cycles after the write.
- `out_ready` held 0 for 5 cycles with bank 4 valid -> `out_valid` = 1 and payload stable for all 5 cycles; no further `bank_cmd_ready` until `out_ready` = 1.
- Refresh with `bank_refresh_gnt` rising staggered over 10 cycles:
  - Stimulus: `ref_req` = 1 while bank 2 is valid; `bank_refresh_gnt` rises staggered over 10 cycles.
  - No bank grant from the `ref_req` cycle onward.
  - REFRESH (cas = ras = 1, we = 0) is issued one cycle after the final gnt.
  - `ref_ack` pulses for 1 cycle; `bank_refresh_req` stays 1 until `ref_req` = 0.
- `sys_rst_n` pulsed low asynchronously while `out_valid` = 1 and the FSM is in WAIT -> `out_valid`, `ref_ack` and `bank_refresh_req` are 0 immediately; after release, the FSM is NORMAL and the pointer is 0.

Source files
------------

// File: rtl/bank_cmd_arbiter_if.sv
// Command and refresh handshake bundle between the bank machines, the command
// arbiter (slave side) and the PHY-side command slot.
interface bank_cmd_arbiter_if #(
    parameter int unsigned NBANKS = 8,
    parameter int unsigned AW     = 17
);
    logic [NBANKS-1:0]    bank_cmd_valid;
    logic [NBANKS-1:0]    bank_cmd_ready;
    logic [NBANKS-1:0]    bank_cmd_first;
    logic [NBANKS-1:0]    bank_cmd_last;
    logic [NBANKS*AW-1:0] bank_cmd_a;
    logic [NBANKS*3-1:0]  bank_cmd_ba;
    logic [NBANKS-1:0]    bank_cmd_cas;
    logic [NBANKS-1:0]    bank_cmd_ras;
    logic [NBANKS-1:0]    bank_cmd_we;
    logic [NBANKS-1:0]    bank_cmd_is_cmd;
    logic [NBANKS-1:0]    bank_cmd_is_read;
    logic [NBANKS-1:0]    bank_cmd_is_write;
    logic [NBANKS-1:0]    bank_refresh_req;
    logic [NBANKS-1:0]    bank_refresh_gnt;

    logic                 out_valid;
    logic                 out_ready;
    logic [AW-1:0]        out_a;
    logic [2:0]           out_ba;
    logic                 out_cas;
    logic                 out_ras;
    logic                 out_we;
    logic                 out_is_read;
    logic                 out_is_write;

    modport slave (
        input  bank_cmd_valid, bank_cmd_a, bank_cmd_ba, bank_cmd_cas, bank_cmd_ras,
               bank_cmd_we, bank_cmd_is_cmd, bank_cmd_is_read, bank_cmd_is_write,
               bank_refresh_gnt, out_ready,
        output bank_cmd_ready, bank_cmd_first, bank_cmd_last, bank_refresh_req,
               out_valid, out_a, out_ba, out_cas, out_ras, out_we, out_is_read, out_is_write
    );

    modport master (
        output bank_cmd_valid, bank_cmd_a, bank_cmd_ba, bank_cmd_cas, bank_cmd_ras,
               bank_cmd_we, bank_cmd_is_cmd, bank_cmd_is_read, bank_cmd_is_write,
               bank_refresh_gnt, out_ready,
        input  bank_cmd_ready, bank_cmd_first, bank_cmd_last, bank_refresh_req,
               out_valid, out_a, out_ba, out_cas, out_ras, out_we, out_is_read, out_is_write
    );
endinterface

// File: rtl/bank_cmd_arbiter.sv
// Round-robin arbiter over the bank-machine command streams with inter-bank
// tRRD/tCCD/tWTR spacing and the refresh handshake; one registered output slot.
module bank_cmd_arbiter #(
    parameter int unsigned NBANKS = 8,
    parameter int unsigned AW     = 17
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    bank_cmd_arbiter_if.slave        bus,
    input  logic                     ref_req,
    output logic                     ref_ack,
    input  logic [7:0]               tRRD_cfg,
    input  logic [7:0]               tCCD_cfg,
    input  logic [7:0]               tWTR_cfg
);
    localparam int unsigned BW = (NBANKS > 1) ? $clog2(NBANKS) : 1;
    localparam int unsigned CW = 8;
    localparam logic [1:0]  T_RRD = 2'd0;
    localparam logic [1:0]  T_CCD = 2'd1;
    localparam logic [1:0]  T_WTR = 2'd2;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [2:0]    ba;
        logic          cas;
        logic          ras;
        logic          we;
        logic          is_read;
        logic          is_write;
    } cmd_t;

    typedef enum logic [2:0] {
        ST_NORMAL = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [BW-1:0]     rr_ptr;
    cmd_t              out_q, grant_cmd;
    logic              out_valid_q;
    logic              refresh_req_q;

    logic [NBANKS-1:0] is_act, is_rd, is_wr, elig;
    logic [AW-1:0]     a_arr  [NBANKS];
    logic [2:0]        ba_arr [NBANKS];

    logic [CW-1:0]     t_cfg  [3];
    logic [CW-1:0]     t_eff  [3];
    logic [CW-1:0]     t_cnt  [3];
    logic [2:0]        t_rdy;
    logic [2:0]        t_ld;

    logic              grant_any;
    logic [BW-1:0]     grant_idx;
    logic [BW-1:0]     cand;
    logic              out_free;
    logic              arb_en;
    logic              issue;
    logic              load;
    logic              unused_is_cmd;

    assign unused_is_cmd = ^bus.bank_cmd_is_cmd;
    assign out_free      = ~out_valid_q | bus.out_ready;

    // Per-bank command class decode and timing eligibility
    for (genvar i = 0; i < NBANKS; i++) begin : g_bank
        assign is_act[i] = bus.bank_cmd_ras[i] & ~bus.bank_cmd_cas[i] & ~bus.bank_cmd_we[i];
        assign is_rd[i]  = bus.bank_cmd_cas[i] & bus.bank_cmd_is_read[i];
        assign is_wr[i]  = bus.bank_cmd_cas[i] & bus.bank_cmd_is_write[i];
        assign elig[i]   = bus.bank_cmd_valid[i]
                         & (~is_act[i] | t_rdy[T_RRD])
                         & (~is_rd[i]  | (t_rdy[T_CCD] & t_rdy[T_WTR]))
                         & (~is_wr[i]  | t_rdy[T_CCD]);
        assign a_arr[i]  = bus.bank_cmd_a[i*AW +: AW];
        assign ba_arr[i] = bus.bank_cmd_ba[i*3 +: 3];
    end

    // First eligible bank at or after the pointer, wrapping
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NBANKS; k++) begin
            cand = BW'((32'(rr_ptr) + k) % NBANKS);
            if (!grant_any && elig[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign load = arb_en & out_free & grant_any;

    assign bus.bank_cmd_ready = load ? (NBANKS'(1) << grant_idx) : '0;
    assign bus.bank_cmd_first = bus.bank_cmd_ready;
    assign bus.bank_cmd_last  = bus.bank_cmd_ready;

    assign grant_cmd.a        = a_arr[grant_idx];
    assign grant_cmd.ba       = ba_arr[grant_idx];
    assign grant_cmd.cas      = bus.bank_cmd_cas[grant_idx];
    assign grant_cmd.ras      = bus.bank_cmd_ras[grant_idx];
    assign grant_cmd.we       = bus.bank_cmd_we[grant_idx];
    assign grant_cmd.is_read  = bus.bank_cmd_is_read[grant_idx];
    assign grant_cmd.is_write = bus.bank_cmd_is_write[grant_idx];

    // Spacing timers: the next same-class grant is allowed cfg cycles after a load
    assign t_cfg[T_RRD] = tRRD_cfg;
    assign t_cfg[T_CCD] = tCCD_cfg;
    assign t_cfg[T_WTR] = tWTR_cfg;
    assign t_ld[T_RRD]  = load & is_act[grant_idx];
    assign t_ld[T_CCD]  = load & (is_rd[grant_idx] | is_wr[grant_idx]);
    assign t_ld[T_WTR]  = load & is_wr[grant_idx];

    for (genvar j = 0; j < 3; j++) begin : g_tmr
        assign t_eff[j] = (t_cfg[j] == '0) ? CW'(1) : t_cfg[j];

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                t_cnt[j] <= '0;
                t_rdy[j] <= 1'b1;
            end else if (t_ld[j]) begin
                t_cnt[j] <= t_eff[j] - CW'(1);
                t_rdy[j] <= (t_eff[j] == CW'(1));
            end else if (!t_rdy[j]) begin
                t_cnt[j] <= t_cnt[j] - CW'(1);
                if (t_cnt[j] == CW'(1)) t_rdy[j] <= 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= ST_NORMAL;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_NORMAL: if (ref_req) state_nxt = ST_DRAIN;
            ST_DRAIN:  if ((&bus.bank_refresh_gnt) && out_free) state_nxt = ST_ISSUE;
            ST_ISSUE:  state_nxt = ST_WAIT;
            ST_WAIT:   if (out_valid_q && bus.out_ready) state_nxt = ST_DONE;
            ST_DONE:   if (!ref_req) state_nxt = ST_NORMAL;
            default:   state_nxt = ST_NORMAL;
        endcase
    end

    // ref_req blocks grants in the very cycle it is seen
    always_comb begin
        arb_en  = 1'b0;
        issue   = 1'b0;
        ref_ack = 1'b0;
        unique case (state)
            ST_NORMAL: arb_en  = ~ref_req;
            ST_ISSUE:  issue   = 1'b1;
            ST_WAIT:   ref_ack = out_valid_q & bus.out_ready;
            default:   ;
        endcase
    end

    // Output slot, round-robin pointer and refresh request register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_q         <= '0;
            out_valid_q   <= 1'b0;
            rr_ptr        <= '0;
            refresh_req_q <= 1'b0;
        end else begin
            refresh_req_q <= (state_nxt != ST_NORMAL);
            if (load) begin
                out_valid_q <= 1'b1;
                out_q       <= grant_cmd;
                rr_ptr      <= (grant_idx == BW'(NBANKS - 1)) ? '0 : grant_idx + BW'(1);
            end else if (issue) begin
                out_valid_q       <= 1'b1;
                out_q             <= '0;
                out_q.cas         <= 1'b1;
                out_q.ras         <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.bank_refresh_req = {NBANKS{refresh_req_q}};
    assign bus.out_valid        = out_valid_q;
    assign bus.out_a            = out_q.a;
    assign bus.out_ba           = out_q.ba;
    assign bus.out_cas          = out_q.cas;
    assign bus.out_ras          = out_q.ras;
    assign bus.out_we           = out_q.we;
    assign bus.out_is_read      = out_q.is_read;
    assign bus.out_is_write     = out_q.is_write;
endmodule

// File: tb/tb_bank_cmd_arbiter.sv
// Bench for bank_cmd_arbiter: directed scenarios plus a randomized run checked
// against a cycle-count based model of arbitration and spacing.
module tb_bank_cmd_arbiter;
    localparam int unsigned NB = 8;
    localparam int unsigned AW = 17;
    localparam int C_OTHER = 0, C_ACT = 1, C_RD = 2, C_WR = 3;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       ref_req;
    logic       ref_ack;
    logic [7:0] tRRD_cfg, tCCD_cfg, tWTR_cfg;

    int n_cmp  = 0;
    int n_fail = 0;

    bit          bv   [NB];
    int          bcls [NB];
    logic [16:0] b_a  [NB];
    logic [2:0]  b_ba [NB];

    bank_cmd_arbiter_if #(.NBANKS(NB), .AW(AW)) bus ();

    bank_cmd_arbiter #(.NBANKS(NB), .AW(AW)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus),
        .ref_req  (ref_req),
        .ref_ack  (ref_ack),
        .tRRD_cfg (tRRD_cfg),
        .tCCD_cfg (tCCD_cfg),
        .tWTR_cfg (tWTR_cfg)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [16:0] addr_of(int i);
        return 17'(32'h1000 + i * 32'h111);
    endfunction

    task automatic drive_banks();
        for (int i = 0; i < NB; i++) begin
            bus.bank_cmd_valid[i]     = bv[i];
            bus.bank_cmd_a[i*AW +: AW] = b_a[i];
            bus.bank_cmd_ba[i*3 +: 3] = b_ba[i];
            bus.bank_cmd_ras[i]       = (bcls[i] == C_ACT) || (bcls[i] == C_OTHER);
            bus.bank_cmd_cas[i]       = (bcls[i] == C_RD) || (bcls[i] == C_WR);
            bus.bank_cmd_we[i]        = (bcls[i] == C_WR) || (bcls[i] == C_OTHER);
            bus.bank_cmd_is_cmd[i]    = 1'b1;
            bus.bank_cmd_is_read[i]   = (bcls[i] == C_RD);
            bus.bank_cmd_is_write[i]  = (bcls[i] == C_WR);
        end
    endtask

    task automatic set_bank(int i, int c);
        bv[i] = 1'b1; bcls[i] = c; b_a[i] = addr_of(i); b_ba[i] = 3'(i);
    endtask

    task automatic clear_banks();
        for (int i = 0; i < NB; i++) bv[i] = 1'b0;
        drive_banks();
    endtask

    // Leaves the bench at posedge+1 with all banks idle and the slot drained
    task automatic idle(int n);
        clear_banks();
        bus.out_ready = 1'b1;
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0; ref_req = 1'b0;
        tRRD_cfg = 8'd1; tCCD_cfg = 8'd1; tWTR_cfg = 8'd1;
        bus.out_ready = 1'b1; bus.bank_refresh_gnt = '0;
        for (int i = 0; i < NB; i++) begin bv[i] = 0; bcls[i] = C_OTHER; b_a[i] = '0; b_ba[i] = '0; end
        drive_banks();
        #3;
        n_cmp++;
        if ({bus.out_valid, ref_ack, bus.bank_refresh_req, bus.bank_cmd_ready} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got valid=%b ack=%b rreq=%h rdy=%h want all 0",
                     bus.out_valid, ref_ack, bus.bank_refresh_req, bus.bank_cmd_ready);
        end
        #19 sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        @(negedge sys_clk);
        n_cmp++;
        if ({bus.out_valid, bus.out_a, bus.out_cas, bus.out_ras} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_release got valid=%b a=%h want 0", bus.out_valid, bus.out_a);
        end
        idle(2);
    endtask

    task automatic test_round_robin();
        int order[3];
        logic [7:0] exp_rdy;
        order = '{0, 3, 5};
        idle(4);
        for (int i = 0; i < 3; i++) set_bank(order[i], C_RD);
        drive_banks();
        for (int k = 0; k < 4; k++) begin
            @(negedge sys_clk);
            exp_rdy = (k < 3) ? (8'd1 << order[k]) : 8'd0;
            n_cmp++;
            if (bus.bank_cmd_ready !== exp_rdy || bus.bank_cmd_first !== exp_rdy || bus.bank_cmd_last !== exp_rdy) begin
                n_fail++;
                $display("FAIL rr_ready k=%0d got=%h first=%h last=%h want=%h", k,
                         bus.bank_cmd_ready, bus.bank_cmd_first, bus.bank_cmd_last, exp_rdy);
            end
            if (k > 0) begin
                n_cmp++;
                if ({bus.out_valid, bus.out_a, bus.out_is_read} !== {1'b1, addr_of(order[k-1]), 1'b1}) begin
                    n_fail++;
                    $display("FAIL rr_out k=%0d got v=%b a=%h want v=1 a=%h", k, bus.out_valid,
                             bus.out_a, addr_of(order[k-1]));
                end
            end
            @(posedge sys_clk); #1;
            if (k < 3) begin bv[order[k]] = 0; drive_banks(); end
        end
        @(negedge sys_clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rr_drain got valid=%b want 0", bus.out_valid);
        end
        @(posedge sys_clk); #1;
        set_bank(0, C_OTHER); set_bank(5, C_OTHER); set_bank(7, C_OTHER); drive_banks();
        @(negedge sys_clk);
        n_cmp++;
        if (bus.bank_cmd_ready !== 8'h80) begin
            n_fail++; $display("FAIL rr_pointer6 got rdy=%h want 80", bus.bank_cmd_ready);
        end
        @(posedge sys_clk); #1;
        clear_banks();
    endtask

    task automatic test_trrd();
        logic [7:0] exp_rdy;
        tRRD_cfg = 8'd4;
        idle(8);
        set_bank(1, C_ACT); set_bank(2, C_ACT); drive_banks();
        for (int k = 0; k < 5; k++) begin
            @(negedge sys_clk);
            exp_rdy = (k == 0) ? 8'h02 : (k == 4) ? 8'h04 : 8'h00;
            n_cmp++;
            if (bus.bank_cmd_ready !== exp_rdy) begin
                n_fail++; $display("FAIL trrd_ready t+%0d got=%h want=%h", k, bus.bank_cmd_ready, exp_rdy);
            end
            @(posedge sys_clk); #1;
            if (k == 0) begin bv[1] = 0; drive_banks(); end
        end
        clear_banks();
    endtask

    task automatic test_twtr();
        logic [7:0] exp_rdy;
        tCCD_cfg = 8'd2; tWTR_cfg = 8'd6;
        idle(8);
        set_bank(0, C_WR); set_bank(1, C_RD); drive_banks();
        for (int k = 0; k < 7; k++) begin
            @(negedge sys_clk);
            exp_rdy = (k == 0) ? 8'h01 : (k == 6) ? 8'h02 : 8'h00;
            n_cmp++;
            if (bus.bank_cmd_ready !== exp_rdy) begin
                n_fail++; $display("FAIL twtr_ready t+%0d got=%h want=%h", k, bus.bank_cmd_ready, exp_rdy);
            end
            @(posedge sys_clk); #1;
            if (k == 0) begin bv[0] = 0; drive_banks(); end
        end
        clear_banks();
    endtask

    task automatic test_backpressure();
        logic [7:0]  exp_rdy;
        logic [16:0] exp_a;
        idle(8);
        bus.out_ready = 1'b0;
        set_bank(4, C_OTHER); set_bank(6, C_OTHER); drive_banks();
        for (int k = 0; k < 8; k++) begin
            @(negedge sys_clk);
            exp_rdy = (k == 0) ? 8'h10 : (k == 6) ? 8'h40 : 8'h00;
            exp_a   = (k == 7) ? addr_of(6) : addr_of(4);
            n_cmp++;
            if (bus.bank_cmd_ready !== exp_rdy) begin
                n_fail++; $display("FAIL bp_ready k=%0d got=%h want=%h", k, bus.bank_cmd_ready, exp_rdy);
            end
            if (k > 0) begin
                n_cmp++;
                if ({bus.out_valid, bus.out_a, bus.out_ba} !== {1'b1, exp_a, (k == 7) ? 3'd6 : 3'd4}) begin
                    n_fail++; $display("FAIL bp_hold k=%0d got v=%b a=%h want v=1 a=%h", k,
                                       bus.out_valid, bus.out_a, exp_a);
                end
            end
            @(posedge sys_clk); #1;
            if (k == 0) bv[4] = 0;
            if (k == 6) bv[6] = 0;
            if (k == 5) bus.out_ready = 1'b1;
            drive_banks();
        end
        clear_banks();
    endtask

    task automatic test_refresh();
        int rise[8];
        logic [7:0] g;
        rise = '{1, 2, 4, 5, 6, 8, 9, 10};
        idle(8);
        set_bank(2, C_OTHER); drive_banks();
        ref_req = 1'b1;
        bus.bank_refresh_gnt = '0;
        for (int k = 0; k < 15; k++) begin
            g = '0;
            for (int j = 0; j < 8; j++) if (rise[j] <= k) g[j] = 1'b1;
            bus.bank_refresh_gnt = g;
            if (k == 13) ref_req = 1'b0;
            @(negedge sys_clk);
            n_cmp++;
            if (bus.bank_cmd_ready !== ((k == 14) ? 8'h04 : 8'h00)) begin
                n_fail++; $display("FAIL ref_nogrant k=%0d got rdy=%h", k, bus.bank_cmd_ready);
            end
            n_cmp++;
            if (bus.bank_refresh_req !== ((k == 0 || k == 14) ? 8'h00 : 8'hff)) begin
                n_fail++; $display("FAIL ref_req_out k=%0d got=%h", k, bus.bank_refresh_req);
            end
            n_cmp++;
            if ({bus.out_valid, ref_ack} !== ((k == 12) ? 2'b11 : 2'b00)) begin
                n_fail++; $display("FAIL ref_slot k=%0d got valid=%b ack=%b", k, bus.out_valid, ref_ack);
            end
            if (k == 12) begin
                n_cmp++;
                if ({bus.out_a, bus.out_ba, bus.out_cas, bus.out_ras, bus.out_we, bus.out_is_read, bus.out_is_write}
                    !== {17'd0, 3'd0, 5'b11000}) begin
                    n_fail++; $display("FAIL ref_cmd got a=%h ba=%h cas=%b ras=%b we=%b want a=0 cas=1 ras=1 we=0",
                                       bus.out_a, bus.out_ba, bus.out_cas, bus.out_ras, bus.out_we);
                end
            end
            @(posedge sys_clk); #1;
        end
        bus.bank_refresh_gnt = '0;
        clear_banks();
    endtask

    task automatic test_reset_mid();
        idle(8);
        bus.out_ready = 1'b0;
        bus.bank_refresh_gnt = 8'hff;
        ref_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) ref_req = 1'b0;
            @(negedge sys_clk);
            if (k >= 3) begin
                n_cmp++;
                if ({bus.out_valid, ref_ack, bus.bank_refresh_req} !== {2'b10, 8'hff}) begin
                    n_fail++; $display("FAIL mid_wait k=%0d got valid=%b ack=%b rreq=%h", k,
                                       bus.out_valid, ref_ack, bus.bank_refresh_req);
                end
            end
            if (k < 4) begin @(posedge sys_clk); #1; end
        end
        #1 bus.out_ready = 1'b1;
        #1;
        n_cmp++;
        if (ref_ack !== 1'b1) begin n_fail++; $display("FAIL mid_ack_pre got=%b want 1", ref_ack); end
        sys_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.out_valid, ref_ack, bus.bank_refresh_req} !== 10'd0) begin
            n_fail++; $display("FAIL mid_reset got valid=%b ack=%b rreq=%h want 0", bus.out_valid,
                               ref_ack, bus.bank_refresh_req);
        end
        @(posedge sys_clk); #2;
        sys_rst_n = 1'b1;
        bus.bank_refresh_gnt = '0;
        set_bank(1, C_OTHER); set_bank(5, C_OTHER); drive_banks();
        @(negedge sys_clk);
        n_cmp++;
        if ({bus.bank_cmd_ready, bus.bank_refresh_req} !== {8'h02, 8'h00}) begin
            n_fail++; $display("FAIL mid_after got rdy=%h rreq=%h want rdy=02 rreq=00",
                               bus.bank_cmd_ready, bus.bank_refresh_req);
        end
        @(posedge sys_clk); #1;
        clear_banks();
    endtask

    // Model: eligibility from cycles elapsed since the last grant of each class
    task automatic test_random();
        int last_act, last_cas, last_wr, ptr, g, j, m_cls;
        int e_rrd, e_ccd, e_wtr;
        bit mov, ld, ordy, ok;
        logic [16:0] m_a;
        logic [2:0]  m_ba;
        logic [7:0]  exp_rdy;
        logic [24:0] exp_o, got_o;
        tRRD_cfg = 8'($urandom_range(0, 6));
        tCCD_cfg = 8'($urandom_range(0, 6));
        tWTR_cfg = 8'($urandom_range(0, 6));
        e_rrd = (tRRD_cfg == 0) ? 1 : int'(tRRD_cfg);
        e_ccd = (tCCD_cfg == 0) ? 1 : int'(tCCD_cfg);
        e_wtr = (tWTR_cfg == 0) ? 1 : int'(tWTR_cfg);
        clear_banks();
        @(negedge sys_clk); sys_rst_n = 1'b0;
        @(posedge sys_clk); #1 sys_rst_n = 1'b1;
        last_act = -1000; last_cas = -1000; last_wr = -1000;
        ptr = 0; mov = 0; m_a = '0; m_ba = '0; m_cls = C_OTHER;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NB; i++) begin
                if (!bv[i] && $urandom_range(0, 9) < 4) begin
                    bv[i] = 1'b1; bcls[i] = int'($urandom_range(0, 3));
                    b_a[i] = 17'($urandom); b_ba[i] = 3'($urandom);
                end
            end
            ordy = ($urandom_range(0, 3) != 0);
            bus.out_ready = ordy;
            drive_banks();
            g = -1;
            for (int k = 0; k < NB; k++) begin
                j = (ptr + k) % NB;
                case (bcls[j])
                    C_ACT:   ok = (c - last_act >= e_rrd);
                    C_RD:    ok = (c - last_cas >= e_ccd) && (c - last_wr >= e_wtr);
                    C_WR:    ok = (c - last_cas >= e_ccd);
                    default: ok = 1'b1;
                endcase
                if (g < 0 && bv[j] && ok) g = j;
            end
            ld = (!mov || ordy) && (g >= 0);
            exp_rdy = ld ? (8'd1 << g) : 8'd0;
            exp_o = {m_a, m_ba, (m_cls == C_RD || m_cls == C_WR), (m_cls == C_ACT || m_cls == C_OTHER),
                     (m_cls == C_WR || m_cls == C_OTHER), (m_cls == C_RD), (m_cls == C_WR)};
            @(negedge sys_clk);
            n_cmp++;
            if (bus.bank_cmd_ready !== exp_rdy || bus.bank_cmd_first !== exp_rdy || bus.bank_cmd_last !== exp_rdy) begin
                n_fail++; $display("FAIL rnd_ready c=%0d got=%h want=%h", c, bus.bank_cmd_ready, exp_rdy);
            end
            n_cmp++;
            if (bus.out_valid !== mov) begin
                n_fail++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, bus.out_valid, mov);
            end
            if (mov) begin
                got_o = {bus.out_a, bus.out_ba, bus.out_cas, bus.out_ras, bus.out_we,
                         bus.out_is_read, bus.out_is_write};
                n_cmp++;
                if (got_o !== exp_o) begin
                    n_fail++; $display("FAIL rnd_payload c=%0d got=%h want=%h", c, got_o, exp_o);
                end
            end
            @(posedge sys_clk);
            if (ld) begin
                mov = 1'b1; m_a = b_a[g]; m_ba = b_ba[g]; m_cls = bcls[g];
                ptr = (g + 1) % NB;
                if (bcls[g] == C_ACT) last_act = c;
                if (bcls[g] == C_RD || bcls[g] == C_WR) last_cas = c;
                if (bcls[g] == C_WR) last_wr = c;
                bv[g] = 1'b0;
            end else if (ordy) begin
                mov = 1'b0;
            end
            #1;
        end
        tRRD_cfg = 8'd1; tCCD_cfg = 8'd1; tWTR_cfg = 8'd1;
        clear_banks();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_trrd();
        test_twtr();
        test_backpressure();
        test_random();
        test_refresh();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
